// File: rtl/pico_io_sequencer_if.sv
// Bundle of the stream and processor-side signals around pico_io_sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface pico_io_sequencer_if #(
   parameter int N = 8
);
   logic [N-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         cpu_wait;
   logic [N-1:0] cpu_out_bus;
   logic [N-1:0] cpu_in_bus;
   logic         io_handshake;
   logic [15:0]  xfer_count;
   logic         err_timeout;

   modport slave (
      input  in_data, in_valid, out_ready, cpu_wait, cpu_out_bus,
      output in_ready, out_data, out_valid, cpu_in_bus, io_handshake,
             xfer_count, err_timeout
   );

   modport master (
      output in_data, in_valid, out_ready, cpu_wait, cpu_out_bus,
      input  in_ready, out_data, out_valid, cpu_in_bus, io_handshake,
             xfer_count, err_timeout
   );
endinterface

// File: rtl/pico_io_sequencer.sv
// Handshake sequencer between the picoMIPS I/O port and two valid/ready
// streams: buffers input words, presents one on cpu_in_bus, captures
// cpu_out_bus, then pulses io_handshake once the input bus has settled.
module pico_io_sequencer #(
   parameter int N              = 8,
   parameter int InDepth        = 4,
   parameter int SettleCycles   = 2,
   parameter int ReleaseTimeout = 16
) (
   input  logic               clk,
   input  logic               reset,
   pico_io_sequencer_if.slave bus
);
   localparam int AW = $clog2(InDepth);
   localparam int SW = $clog2(SettleCycles) + 1;
   localparam int RW = $clog2(ReleaseTimeout);
   localparam logic [AW:0] PTR_ONE = 1;
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SettleCycles - 1);
   localparam logic [RW-1:0] REL_LOAD = RW'(ReleaseTimeout - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_PULSE, S_RELEASE} state_t;

   logic [N-1:0] fifo_mem [InDepth];
   logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   state_t       state_q, state_d;
   logic [N-1:0] out_data_q, out_data_d, cpu_in_bus_q, cpu_in_bus_d;
   logic         out_valid_q, out_valid_d, err_q, err_d;
   logic [15:0]  xfer_q, xfer_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [RW-1:0] rel_q, rel_d;
   logic         fifo_full, fifo_empty, in_ready, push, start;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign in_ready   = !fifo_full && !reset;
   assign push       = bus.in_valid && in_ready;
   // Output slot is free if empty or being drained in this same cycle.
   assign start      = bus.cpu_wait && !fifo_empty && (!out_valid_q || bus.out_ready);

   assign bus.in_ready     = in_ready;
   assign bus.out_data     = out_data_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.cpu_in_bus   = cpu_in_bus_q;
   assign bus.io_handshake = (state_q == S_PULSE);
   assign bus.xfer_count   = xfer_q;
   assign bus.err_timeout  = err_q;

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= bus.in_data;
      end
   end

   // Next-state logic: FIFO pointers, output slot and the handshake FSM.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      cpu_in_bus_d = cpu_in_bus_q;
      xfer_d       = xfer_q;
      err_d        = err_q;
      settle_d     = settle_q;
      rel_d        = rel_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            // The load happens on the edge leaving IDLE; a capture overrides a same-cycle pop.
            if (start) begin
               out_data_d   = bus.cpu_out_bus;
               out_valid_d  = 1'b1;
               cpu_in_bus_d = fifo_mem[rd_ptr_q[AW-1:0]];
               rd_ptr_d     = rd_ptr_q + PTR_ONE;
               settle_d     = SETTLE_LOAD;
               state_d      = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (settle_q == '0) begin
               state_d = S_PULSE;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         S_PULSE: begin
            xfer_d  = xfer_q + 16'd1;
            rel_d   = REL_LOAD;
            state_d = S_RELEASE;
         end
         S_RELEASE: begin
            if (!bus.cpu_wait) begin
               state_d = S_IDLE;
            end else if (rel_q == '0) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               rel_d = rel_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset; reset abandons any in-flight transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         cpu_in_bus_q <= '0;
         xfer_q       <= '0;
         err_q        <= 1'b0;
         settle_q     <= '0;
         rel_q        <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         cpu_in_bus_q <= cpu_in_bus_d;
         xfer_q       <= xfer_d;
         err_q        <= err_d;
         settle_q     <= settle_d;
         rel_q        <= rel_d;
      end
   end
endmodule

// File: tb/tb_pico_io_sequencer.sv
// Directed bench for pico_io_sequencer: a SettleCycles=2 instance for the
// main scenarios and a SettleCycles=4 instance for reset during SETTLE.
module tb_pico_io_sequencer;
   logic clk = 1'b0;
   logic reset, reset4;
   always #5 clk = ~clk;

   pico_io_sequencer_if #(.N(8)) bus ();
   pico_io_sequencer_if #(.N(8)) bus4 ();

   pico_io_sequencer #(.N(8), .InDepth(4), .SettleCycles(2), .ReleaseTimeout(16)) u_dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   pico_io_sequencer #(.N(8), .InDepth(4), .SettleCycles(4), .ReleaseTimeout(16)) u_dut4 (
      .clk(clk), .reset(reset4), .bus(bus4)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] exp_in[$];
   logic [7:0] exp_out[$];
   int exp_xfer = 0;
   int pulses = 0, pulses4 = 0, dbl = 0;
   logic hs_prev = 1'b0;

   // Pulse monitor: counts handshakes and back-to-back highs.
   always @(negedge clk) begin
      if (bus.io_handshake === 1'b1) begin
         pulses++;
         if (hs_prev) dbl++;
      end
      hs_prev = (bus.io_handshake === 1'b1);
      if (bus4.io_handshake === 1'b1) pulses4++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] d);
      logic exp_rdy;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      mid();
      exp_rdy = (exp_in.size() < 4);
      chk($sformatf("in_ready_push_%02h", d), {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      if (exp_rdy) exp_in.push_back(d);
      $display("push 0x%02h accepted=%0d", d, exp_rdy);
      next();
      bus.in_valid = 1'b0;
   endtask

   // Waits (bounded) for a handshake pulse and scores it against the queues.
   task automatic wait_pulse(input string tag, input int maxc);
      logic got;
      logic [7:0] ei, eo;
      got = 1'b0;
      for (int i = 0; i < maxc && !got; i++) begin
         mid();
         if (bus.io_handshake === 1'b1) got = 1'b1;
         else next();
      end
      chk({tag, "_pulse_seen"}, {31'd0, got}, 32'd1);
      if (got) begin
         chk({tag, "_queue"}, (exp_in.size() > 0 && exp_out.size() > 0) ? 32'd1 : 32'd0, 32'd1);
         if (exp_in.size() > 0 && exp_out.size() > 0) begin
            ei = exp_in.pop_front();
            eo = exp_out.pop_front();
            chk({tag, "_cpu_in_bus"}, {24'd0, bus.cpu_in_bus}, {24'd0, ei});
            chk({tag, "_out_data"}, {24'd0, bus.out_data}, {24'd0, eo});
            chk({tag, "_xfer_pre"}, {16'd0, bus.xfer_count}, exp_xfer);
            $display("xfer %0d %s: cpu_in_bus=0x%02h out_data=0x%02h", exp_xfer + 1, tag,
                     bus.cpu_in_bus, bus.out_data);
         end
         exp_xfer++;
      end
   endtask

   task automatic transfer(input string tag, input logic [7:0] cpu_out);
      bus.cpu_wait    = 1'b1;
      bus.cpu_out_bus = cpu_out;
      exp_out.push_back(cpu_out);
      wait_pulse(tag, 8);
      next();
      bus.cpu_wait = 1'b0;
      mid();
      chk({tag, "_xfer_post"}, {16'd0, bus.xfer_count}, exp_xfer);
      chk({tag, "_hs_after"}, {31'd0, bus.io_handshake}, 32'd0);
      next();
   endtask

   initial begin
      reset = 1'b1;          reset4 = 1'b1;
      bus.in_valid = 1'b1;   bus.in_data = 8'hAA;  bus.out_ready = 1'b0;
      bus.cpu_wait = 1'b0;   bus.cpu_out_bus = 8'h00;
      bus4.in_valid = 1'b1;  bus4.in_data = 8'hAA; bus4.out_ready = 1'b0;
      bus4.cpu_wait = 1'b0;  bus4.cpu_out_bus = 8'h00;

      // Reset held for three edges with in_valid high.
      for (int i = 0; i < 2; i++) begin
         next();
         mid();
         chk($sformatf("reset_in_ready_%0d", i), {31'd0, bus.in_ready}, 32'd0);
      end
      next();
      reset = 1'b0;  reset4 = 1'b0;
      bus.in_valid = 1'b0;  bus4.in_valid = 1'b0;
      mid();
      chk("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("post_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("post_reset_out_data", {24'd0, bus.out_data}, 32'd0);
      chk("post_reset_cpu_in_bus", {24'd0, bus.cpu_in_bus}, 32'd0);
      chk("post_reset_hs", {31'd0, bus.io_handshake}, 32'd0);
      chk("post_reset_xfer", {16'd0, bus.xfer_count}, 32'd0);
      chk("post_reset_err", {31'd0, bus.err_timeout}, 32'd0);
      chk("post_reset_in_ready4", {31'd0, bus4.in_ready}, 32'd1);
      next();

      // FIFO must be empty after reset: cpu_wait alone must not start a load.
      bus.cpu_wait = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mid();
         chk($sformatf("empty_no_load_%0d", i), {23'd0, bus.io_handshake, bus.cpu_in_bus}, 32'd0);
         next();
      end
      bus.cpu_wait = 1'b0;
      next();

      // Basic transfer with explicit cycle-by-cycle timing.
      push(8'h5A);
      bus.cpu_wait = 1'b1;  bus.cpu_out_bus = 8'h3C;  exp_out.push_back(8'h3C);
      mid();
      chk("basic_t_hs", {31'd0, bus.io_handshake}, 32'd0);
      next();
      mid();
      chk("basic_t1_cpu_in_bus", {24'd0, bus.cpu_in_bus}, 32'h5A);
      chk("basic_t1_out_data", {24'd0, bus.out_data}, 32'h3C);
      chk("basic_t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("basic_t1_hs", {31'd0, bus.io_handshake}, 32'd0);
      next();
      mid();
      chk("basic_t2_hs", {31'd0, bus.io_handshake}, 32'd0);
      next();
      wait_pulse("basic_t3", 1);
      next();
      mid();
      chk("basic_t4_xfer", {16'd0, bus.xfer_count}, 32'd1);
      chk("basic_t4_hs", {31'd0, bus.io_handshake}, 32'd0);
      next();
      bus.cpu_wait = 1'b0;
      next();

      // Fill the FIFO with 0x01..0x05; the fifth must be refused.
      bus.out_ready = 1'b1;
      for (int d = 1; d <= 5; d++) push(8'(d));
      mid();
      chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      next();
      for (int i = 0; i < 4; i++) transfer($sformatf("order%0d", i), 8'(8'h10 + i));

      // Output backpressure: held out_ready=0 blocks the load.
      bus.out_ready = 1'b0;
      push(8'h77);
      push(8'h88);
      transfer("bp_first", 8'h21);
      bus.cpu_wait = 1'b1;  bus.cpu_out_bus = 8'h22;
      for (int i = 0; i < 5; i++) begin
         mid();
         chk($sformatf("bp_stall_hs_%0d", i), {31'd0, bus.io_handshake}, 32'd0);
         chk($sformatf("bp_stall_bus_%0d", i), {bus.out_valid, bus.out_data, bus.cpu_in_bus},
             {15'd0, 1'b1, 8'h21, 8'h77});
         next();
      end
      bus.out_ready = 1'b1;  exp_out.push_back(8'h22);
      next();
      bus.out_ready = 1'b0;
      mid();
      chk("bp_load_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_load_out_data", {24'd0, bus.out_data}, 32'h22);
      chk("bp_load_cpu_in_bus", {24'd0, bus.cpu_in_bus}, 32'h88);
      chk("bp_load_hs", {31'd0, bus.io_handshake}, 32'd0);
      wait_pulse("bp_second", 4);

      // Release timeout: cpu_wait stays high after the pulse, FIFO now empty.
      for (int k = 1; k <= 16; k++) begin
         next();
         mid();
         chk($sformatf("to_wait_%0d", k), {30'd0, bus.err_timeout, bus.io_handshake}, 32'd0);
      end
      next();
      mid();
      chk("to_err_set", {31'd0, bus.err_timeout}, 32'd1);
      chk("to_xfer", {16'd0, bus.xfer_count}, exp_xfer);
      for (int k = 0; k < 5; k++) begin
         next();
         mid();
         chk($sformatf("to_sticky_%0d", k), {30'd0, bus.err_timeout, bus.io_handshake}, 32'd2);
      end
      bus.cpu_wait = 1'b0;
      next();
      next();
      chk("pulse_total", pulses, exp_xfer);
      chk("no_double_pulse", dbl, 32'd0);
      reset = 1'b1;
      next();
      reset = 1'b0;
      mid();
      chk("rst_err_clear", {31'd0, bus.err_timeout}, 32'd0);
      chk("rst_xfer_clear", {16'd0, bus.xfer_count}, 32'd0);
      next();

      // Reset during the second SETTLE cycle (SettleCycles=4).
      bus4.in_valid = 1'b1;  bus4.in_data = 8'h99;
      mid();
      chk("s4_push_ready", {31'd0, bus4.in_ready}, 32'd1);
      next();
      bus4.in_valid = 1'b0;
      bus4.cpu_wait = 1'b1;  bus4.cpu_out_bus = 8'h44;
      next();
      mid();
      chk("s4_load_bus", {bus4.out_valid, bus4.cpu_in_bus}, {23'd0, 1'b1, 8'h99});
      next();
      reset4 = 1'b1;
      next();
      reset4 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         mid();
         chk($sformatf("s4_no_hs_%0d", i), {31'd0, bus4.io_handshake}, 32'd0);
         next();
      end
      chk("s4_pulses", pulses4, 32'd0);
      chk("s4_xfer", {16'd0, bus4.xfer_count}, 32'd0);
      chk("s4_out_valid", {31'd0, bus4.out_valid}, 32'd0);
      chk("s4_cpu_in_bus", {24'd0, bus4.cpu_in_bus}, 32'd0);
      $display("reset-in-settle: pulses=%0d xfer_count=%0d", pulses4, bus4.xfer_count);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
